// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with a one-word holding register.
// A word accepted into the holding register moves to the shift register once
// the shifter is idle or finishing its last bit, so frames stream back to back.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active low
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             data_out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy,
    output logic             state_dbg     // 0 = IDLE, 1 = SHIFT
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             xfer;

    // Handshake: a word moves on a rising edge where load_valid=1 and
    // load_ready=1. load_ready depends only on hold_full_q, never on
    // load_valid, and load_data is sampled only on that transfer edge.
    assign xfer = load_valid && !hold_full_q;

    // Move the shift register one position toward the output end, zero fill.
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return {v[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, v[WIDTH-1:1]};
        end
    endfunction

    // Next-state logic: shift, reload from the holding register, capture loads.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    shreg_d     = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != LAST) begin
                    shreg_d = shift_one(shreg_q);
                    cnt_d   = cnt_q + CW'(1);
                end else if (hold_full_q) begin
                    // Gapless reload: next frame's first bit follows the last bit.
                    shreg_d     = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else begin
                    shreg_d = shift_one(shreg_q);
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A transfer never coincides with a drain: load_ready is low whenever
        // the holding register is full, so these writes cannot collide.
        if (xfer) begin
            hold_d      = load_data;
            hold_full_d = 1'b1;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    // Output decode, registers only.
    assign out_valid   = (state_q == SHIFT);
    assign data_out    = out_valid && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
    assign frame_start = out_valid && (cnt_q == '0);
    assign frame_done  = out_valid && (cnt_q == LAST);
    assign busy        = out_valid || hold_full_q;
    assign load_ready  = !hold_full_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: a default instance (WIDTH=4, MSB first) and a WIDTH=8
// LSB-first instance driven from one clock and one reset.
module tb_piso_tx;

  localparam int W_A = 4;
  localparam int W_B = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           a_load_valid, a_load_ready;
  logic [W_A-1:0] a_load_data;
  logic           a_data_out, a_out_valid, a_frame_start, a_frame_done, a_busy, a_state_dbg;

  logic           b_load_valid, b_load_ready;
  logic [W_B-1:0] b_load_data;
  logic           b_data_out, b_out_valid, b_frame_start, b_frame_done, b_busy, b_state_dbg;

  piso_tx #(.WIDTH(W_A), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .load_valid(a_load_valid), .load_ready(a_load_ready), .load_data(a_load_data),
    .data_out(a_data_out), .out_valid(a_out_valid), .frame_start(a_frame_start),
    .frame_done(a_frame_done), .busy(a_busy), .state_dbg(a_state_dbg)
  );

  piso_tx #(.WIDTH(W_B), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .load_valid(b_load_valid), .load_ready(b_load_ready), .load_data(b_load_data),
    .data_out(b_data_out), .out_valid(b_out_valid), .frame_start(b_frame_start),
    .frame_done(b_frame_done), .busy(b_busy), .state_dbg(b_state_dbg)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model: bits still to send in the current frame, plus one held word
  bit             a_cur_q[$];
  bit             a_held_valid;
  logic [W_A-1:0] a_held;
  logic [W_A-1:0] a_exp_q[$];
  logic [W_A-1:0] a_rx;
  logic [31:0]    a_log;
  int             a_ov_cnt;

  bit             b_cur_q[$];
  bit             b_held_valid;
  logic [W_B-1:0] b_held;
  logic [W_B-1:0] b_exp_q[$];
  logic [W_B-1:0] b_rx;
  logic [31:0]    b_log;
  int             b_ov_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    a_cur_q.delete(); a_held_valid = 1'b0; a_held = '0; a_exp_q.delete(); a_rx = '0;
    b_cur_q.delete(); b_held_valid = 1'b0; b_held = '0; b_exp_q.delete(); b_rx = '0;
  endtask

  // driver/checker: compare this cycle's outputs, advance model, wait one edge
  task automatic cycle();
    bit ev, ed, edn;
    bit rdy;
    if (!rst) model_reset();

    // instance A
    ev  = (a_cur_q.size() > 0);
    ed  = ev ? a_cur_q[0] : 1'b0;
    edn = ev && (a_cur_q.size() == 1);
    check("a_out_valid",   32'(a_out_valid),   32'(ev));
    check("a_data_out",    32'(a_data_out),    32'(ed));
    check("a_frame_start", 32'(a_frame_start), 32'(ev && a_cur_q.size() == W_A));
    check("a_frame_done",  32'(a_frame_done),  32'(edn));
    check("a_load_ready",  32'(a_load_ready),  32'(!a_held_valid));
    check("a_busy",        32'(a_busy),        32'(ev || a_held_valid));
    check("a_state_dbg",   32'(a_state_dbg),   32'(ev));
    if (ev) begin
      a_rx  = {a_rx[W_A-2:0], a_data_out};
      a_log = {a_log[30:0], a_data_out};
      a_ov_cnt++;
      if (edn) begin
        if (a_exp_q.size() > 0) check("a_rx_word", 32'(a_rx), 32'(a_exp_q.pop_front()));
        else check("a_rx_unexpected", 32'(1), 32'(0));
      end
    end

    // instance B (LSB first)
    ev  = (b_cur_q.size() > 0);
    ed  = ev ? b_cur_q[0] : 1'b0;
    edn = ev && (b_cur_q.size() == 1);
    check("b_out_valid",   32'(b_out_valid),   32'(ev));
    check("b_data_out",    32'(b_data_out),    32'(ed));
    check("b_frame_start", 32'(b_frame_start), 32'(ev && b_cur_q.size() == W_B));
    check("b_frame_done",  32'(b_frame_done),  32'(edn));
    check("b_load_ready",  32'(b_load_ready),  32'(!b_held_valid));
    check("b_busy",        32'(b_busy),        32'(ev || b_held_valid));
    check("b_state_dbg",   32'(b_state_dbg),   32'(ev));
    if (ev) begin
      b_rx  = {b_data_out, b_rx[W_B-1:1]};
      b_log = {b_log[30:0], b_data_out};
      b_ov_cnt++;
      if (edn) begin
        if (b_exp_q.size() > 0) check("b_rx_word", 32'(b_rx), 32'(b_exp_q.pop_front()));
        else check("b_rx_unexpected", 32'(1), 32'(0));
      end
    end

    if (rst) begin
      rdy = !a_held_valid;
      if (a_cur_q.size() > 0) void'(a_cur_q.pop_front());
      if (a_cur_q.size() == 0 && a_held_valid) begin
        for (int i = 0; i < W_A; i++) a_cur_q.push_back(a_held[W_A-1-i]);
        a_held_valid = 1'b0;
      end
      if (a_load_valid && rdy) begin
        a_held = a_load_data; a_held_valid = 1'b1; a_exp_q.push_back(a_load_data);
      end

      rdy = !b_held_valid;
      if (b_cur_q.size() > 0) void'(b_cur_q.pop_front());
      if (b_cur_q.size() == 0 && b_held_valid) begin
        for (int i = 0; i < W_B; i++) b_cur_q.push_back(b_held[i]);
        b_held_valid = 1'b0;
      end
      if (b_load_valid && rdy) begin
        b_held = b_load_data; b_held_valid = 1'b1; b_exp_q.push_back(b_load_data);
      end
    end

    @(posedge clk);
    #1;
  endtask

  // offer one word on A until the model says it was taken (bounded)
  task automatic send_a(input logic [W_A-1:0] w);
    bit took;
    took = 1'b0;
    a_load_valid = 1'b1;
    a_load_data  = w;
    for (int k = 0; k < 40 && !took; k++) begin
      took = !a_held_valid;
      cycle();
    end
    if (!took) check("a_send_timeout", 32'(0), 32'(1));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    rst = 1'b0;
    a_load_valid = 1'b0; a_load_data = '0;
    b_load_valid = 1'b0; b_load_data = '0;
    a_log = '0; b_log = '0; a_ov_cnt = 0; b_ov_cnt = 0;
    model_reset();
    #1;

    // 1: reset then idle
    idle(3);
    rst = 1'b1;
    idle(10);

    // 2: single word 1011
    a_log = '0; a_ov_cnt = 0;
    send_a(4'b1011);
    a_load_valid = 1'b0;
    idle(8);
    check("t2_stream", a_log & 32'hF, 32'hB);
    check("t2_len",    32'(a_ov_cnt), 32'(4));

    // 3: back-to-back 1100 0110 0001
    a_log = '0; a_ov_cnt = 0;
    send_a(4'b1100);
    send_a(4'b0110);
    send_a(4'b0001);
    a_load_valid = 1'b0;
    idle(16);
    check("t3_stream", a_log & 32'hFFF, 32'hC61);
    check("t3_len",    32'(a_ov_cnt), 32'(12));

    // 4: backpressure, 1111 offered while held word waits
    send_a(4'b1011);
    send_a(4'b0101);
    a_load_valid = 1'b1;
    a_load_data  = 4'b1111;
    check("t4_ready_low", 32'(a_load_ready), 32'(0));
    idle(2);
    a_load_valid = 1'b0;
    idle(10);
    check("t4_exp_empty", 32'(a_exp_q.size()), 32'(0));

    // 5: WIDTH=8 LSB first, A5
    b_log = '0; b_ov_cnt = 0;
    b_load_valid = 1'b1;
    b_load_data  = 8'hA5;
    cycle();
    b_load_valid = 1'b0;
    idle(12);
    check("t5_stream", b_log & 32'hFF, 32'hA5);
    check("t5_len",    32'(b_ov_cnt), 32'(8));

    // 6: reset mid-frame
    send_a(4'b1011);
    send_a(4'b0101);
    a_load_valid = 1'b0;
    for (int k = 0; k < 20 && a_cur_q.size() != W_A - 2; k++) cycle();
    check("t6_reached_bit2", 32'(a_cur_q.size()), 32'(W_A - 2));
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_out_valid",  32'(a_out_valid),  32'(0));
    check("t6_async_data_out",   32'(a_data_out),   32'(0));
    check("t6_async_frame_done", 32'(a_frame_done), 32'(0));
    check("t6_async_busy",       32'(a_busy),       32'(0));
    check("t6_async_load_ready", 32'(a_load_ready), 32'(1));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    a_ov_cnt = 0;
    idle(10);
    check("t6_nothing_sent", 32'(a_ov_cnt), 32'(0));

    // randomized streaming on both instances
    for (int k = 0; k < 300; k++) begin
      a_load_valid = 1'($urandom_range(0, 1));
      a_load_data  = W_A'($urandom);
      b_load_valid = 1'($urandom_range(0, 1));
      b_load_data  = W_B'($urandom);
      cycle();
    end
    a_load_valid = 1'b0;
    b_load_valid = 1'b0;
    idle(24);
    check("rand_a_drained", 32'(a_exp_q.size()), 32'(0));
    check("rand_b_drained", 32'(b_exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
